// File: rtl/e203_extend_csr_req_pkg.sv
// Shared types and constants for the NICE extended-CSR request initiator.
// Holds the FSM state encoding, the default CSR window and the address width.
package e203_extend_csr_pkg;

    localparam int          NICE_CSR_AW  = 32;
    localparam logic [31:0] EXT_CSR_BASE = 32'h0000_0BC0;
    localparam logic [31:0] EXT_CSR_SIZE = 32'd64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } csr_state_e;

    // Window compare is done in 33 bits so base+size cannot wrap.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] size);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = {1'b0, base} + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/e203_extend_csr_req_if.sv
// Bundles the upstream CSR request/response channel and the downstream NICE CSR channel.
// The master modport is the initiator's view; slave is the core/responder environment.
interface e203_extend_csr_req_if;
    import e203_extend_csr_pkg::*;

    logic                   csr_req_valid;
    logic                   csr_req_ready;
    logic [NICE_CSR_AW-1:0] csr_req_addr;
    logic                   csr_req_wr;
    logic [31:0]            csr_req_wdata;

    logic                   csr_rsp_valid;
    logic                   csr_rsp_ready;
    logic [31:0]            csr_rsp_rdata;
    logic                   csr_rsp_err;

    logic                   nice_csr_valid;
    logic                   nice_csr_ready;
    logic [NICE_CSR_AW-1:0] nice_csr_addr;
    logic                   nice_csr_wr;
    logic [31:0]            nice_csr_wdata;
    logic [31:0]            nice_csr_rdata;

    modport master (
        input  csr_req_valid, csr_req_addr, csr_req_wr, csr_req_wdata,
        output csr_req_ready,
        output csr_rsp_valid, csr_rsp_rdata, csr_rsp_err,
        input  csr_rsp_ready,
        output nice_csr_valid, nice_csr_addr, nice_csr_wr, nice_csr_wdata,
        input  nice_csr_ready, nice_csr_rdata
    );

    modport slave (
        output csr_req_valid, csr_req_addr, csr_req_wr, csr_req_wdata,
        input  csr_req_ready,
        input  csr_rsp_valid, csr_rsp_rdata, csr_rsp_err,
        output csr_rsp_ready,
        input  nice_csr_valid, nice_csr_addr, nice_csr_wr, nice_csr_wdata,
        output nice_csr_ready, nice_csr_rdata
    );

endinterface

// File: rtl/e203_extend_csr_req_tmr.sv
// Timeout counter for a pending downstream request; expired flags the last allowed wait cycle.
// TIMEOUT_CYC of 0 disables expiry entirely.
module e203_extend_csr_req_tmr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC <= 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
    localparam logic ENABLED = (TIMEOUT_CYC > 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = ENABLED && en && (cnt == LAST);

endmodule

// File: rtl/e203_extend_csr_req.sv
// Initiator for one extended-CSR access at a time: range check, NICE handshake, single response.
// Out-of-window accesses and responder timeouts complete with err=1 and zero data.
module e203_extend_csr_req
    import e203_extend_csr_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = EXT_CSR_BASE,
    parameter logic [31:0] ADDR_SIZE   = EXT_CSR_SIZE,
    parameter int          TIMEOUT_CYC = 16
) (
    input logic                  clk,
    input logic                  rst,
    e203_extend_csr_req_if.master bus
);

    csr_state_e state_q;
    csr_state_e state_d;

    logic [NICE_CSR_AW-1:0] addr_q;
    logic                   wr_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic                   err_q;

    logic in_window;
    logic accept;
    logic nice_fire;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;

    assign in_window = addr_in_window(bus.csr_req_addr, ADDR_BASE, ADDR_SIZE);
    assign accept    = bus.csr_req_valid && bus.csr_req_ready;
    assign nice_fire = bus.nice_csr_valid && bus.nice_csr_ready;
    assign tmr_clr   = (state_q != REQ);
    assign tmr_en    = (state_q == REQ) && !bus.nice_csr_ready;

    e203_extend_csr_req_tmr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request ready is forced low while reset is held, even though the state reads IDLE.
    always_comb begin
        state_d            = state_q;
        bus.csr_req_ready  = 1'b0;
        bus.nice_csr_valid = 1'b0;
        bus.csr_rsp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.csr_req_ready = !rst;
                if (accept) begin
                    state_d = in_window ? REQ : RSP;
                end
            end
            REQ: begin
                bus.nice_csr_valid = 1'b1;
                if (bus.nice_csr_ready || tmr_expired) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                bus.csr_rsp_valid = 1'b1;
                if (bus.csr_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready takes priority over expiry, so a late accept still counts as success.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && accept) begin
                addr_q  <= bus.csr_req_addr;
                wr_q    <= bus.csr_req_wr;
                wdata_q <= bus.csr_req_wdata;
                if (!in_window) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
            end else if (state_q == REQ) begin
                if (nice_fire) begin
                    rdata_q <= bus.nice_csr_rdata;
                    err_q   <= 1'b0;
                end else if (tmr_expired) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.nice_csr_addr  = addr_q;
    assign bus.nice_csr_wr    = wr_q;
    assign bus.nice_csr_wdata = wdata_q;
    assign bus.csr_rsp_rdata  = rdata_q;
    assign bus.csr_rsp_err    = err_q;

endmodule
